// File: rtl/boot_loader_if.sv
// Boot loader bus bundle: upstream byte stream (rx_*), processor write port
// (cpu_*) and external byte-memory write port (mem_*).
//   master : byte source / processor / memory side (drives rx_valid, rx_data, cpu_*)
//   slave  : boot_loader side (drives rx_ready, mem_*)
interface boot_loader_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             cpu_memwrite;
  logic [WIDTH-1:0] cpu_adr;
  logic [WIDTH-1:0] cpu_writedata;
  logic             mem_memwrite;
  logic [WIDTH-1:0] mem_adr;
  logic [WIDTH-1:0] mem_writedata;

  modport master (
    output rx_valid, rx_data, cpu_memwrite, cpu_adr, cpu_writedata,
    input  rx_ready, mem_memwrite, mem_adr, mem_writedata
  );

  modport slave (
    input  rx_valid, rx_data, cpu_memwrite, cpu_adr, cpu_writedata,
    output rx_ready, mem_memwrite, mem_adr, mem_writedata
  );
endinterface

// File: rtl/boot_loader.sv
// Boot loader: receives a length-prefixed, checksummed image over a
// valid/ready byte stream, writes it into byte memory from address 0, then
// releases the processor and hands it the memory bus.
//   clk, reset : clock, synchronous active-high reset
//   bus        : boot_loader_if slave (rx stream, cpu port, mem port)
//   cpu_reset  : holds processor in reset until the image is verified
//   boot_done  : image loaded and verified (RUN)
//   boot_err   : sticky checksum failure, cleared by reset or entry to RUN
module boot_loader #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  boot_loader_if.slave bus,
  output logic         cpu_reset,
  output logic         boot_done,
  output logic         boot_err
);
  localparam int unsigned BYTE_W = 8;
  // Count must hold 256 for a zero length byte.
  localparam int unsigned CNT_W  = 9;

  typedef enum logic [2:0] {LEN, DATA, WR, CSUM, ERR, RUN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDTH-1:0]  adr_q;
  logic [BYTE_W-1:0] wdata_q;
  logic [BYTE_W-1:0] sum_q;
  logic [BYTE_W-1:0] csum_total;
  logic              boot_err_q;
  logic              rx_ready_c;
  logic              accept;
  logic              csum_ok;

  // Handshake decoded straight from the state register.
  assign rx_ready_c = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
  assign accept     = bus.rx_valid & rx_ready_c;
  assign csum_total = sum_q + bus.rx_data;
  assign csum_ok    = (csum_total == '0);

  assign bus.rx_ready = rx_ready_c;
  assign cpu_reset    = (state_q != RUN);
  assign boot_done    = (state_q == RUN);
  assign boot_err     = boot_err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= LEN;
    else       state_q <= state_d;
  end

  // Next state and memory-port outputs; RUN hands the bus to the processor.
  always_comb begin
    state_d           = state_q;
    bus.mem_memwrite  = 1'b0;
    bus.mem_adr       = adr_q;
    bus.mem_writedata = WIDTH'(wdata_q);
    case (state_q)
      LEN:  if (accept) state_d = DATA;
      DATA: if (accept) state_d = WR;
      WR: begin
        bus.mem_memwrite = 1'b1;
        state_d          = (cnt_q == CNT_W'(1)) ? CSUM : DATA;
      end
      CSUM: if (accept) state_d = csum_ok ? RUN : ERR;
      ERR:  state_d = LEN;
      RUN: begin
        bus.mem_memwrite  = bus.cpu_memwrite;
        bus.mem_adr       = bus.cpu_adr;
        bus.mem_writedata = bus.cpu_writedata;
      end
      default: state_d = LEN;
    endcase
  end

  // Load datapath: remaining count, address, write data, running sum, error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      adr_q      <= '0;
      wdata_q    <= '0;
      sum_q      <= '0;
      boot_err_q <= 1'b0;
    end else begin
      case (state_q)
        LEN: if (accept) begin
          cnt_q <= (bus.rx_data == '0) ? CNT_W'(256) : CNT_W'(bus.rx_data);
          adr_q <= '0;
          sum_q <= '0;
        end
        DATA: if (accept) begin
          wdata_q <= bus.rx_data;
          sum_q   <= sum_q + bus.rx_data;
        end
        WR: begin
          adr_q <= adr_q + WIDTH'(1);
          cnt_q <= cnt_q - CNT_W'(1);
        end
        // Set on the way into ERR, cleared on the way into RUN.
        CSUM: if (accept) boot_err_q <= ~csum_ok;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed and randomized images
// checked against an image-level reference model and a memory write log.
module tb_boot_loader;
  localparam int unsigned WIDTH = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic cpu_reset, boot_done, boot_err;

  boot_loader_if #(.WIDTH(WIDTH)) bus ();

  boot_loader #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .boot_done (boot_done),
    .boot_err  (boot_err)
  );

  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_fail = 0;
  bit         rand_gap = 1'b0;
  logic [7:0] tb_mem [256];
  logic [7:0] wq_adr [$];
  logic [7:0] wq_dat [$];
  logic [7:0] img [$];

  // External byte memory plus a log of every write in order.
  always @(posedge clk) begin
    if (bus.mem_memwrite === 1'b1) begin
      tb_mem[bus.mem_adr] = bus.mem_writedata;
      wq_adr.push_back(bus.mem_adr);
      wq_dat.push_back(bus.mem_writedata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset             = 1'b1;
    bus.rx_valid      = 1'b0;
    bus.rx_data       = 8'h00;
    bus.cpu_memwrite  = 1'b0;
    bus.cpu_adr       = '0;
    bus.cpu_writedata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    forever begin
      if (rand_gap && $urandom_range(0, 2) == 0) begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
      end else begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
      end
      if (bus.rx_valid && bus.rx_ready) begin
        check("no_wr_on_accept", 32'(bus.mem_memwrite), 32'd0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        return;
      end
      @(negedge clk);
      t++;
      if (t > 1000) begin
        check("rx_timeout", 32'(t), 32'd0);
        bus.rx_valid = 1'b0;
        return;
      end
    end
  endtask

  // Sends len, img[], csum and checks writes and outcome against the model.
  task automatic send_image(input logic [7:0] len, input logic [7:0] c);
    int n, t, errs, sum;
    bit ok;
    n   = (len == 8'd0) ? 256 : int'(len);
    sum = int'(c);
    foreach (img[i]) sum += int'(img[i]);
    ok = ((sum % 256) == 0);
    wq_adr.delete();
    wq_dat.delete();
    send_byte(len);
    foreach (img[i]) send_byte(img[i]);
    t = 0;
    while (bus.rx_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("csum_ready", 32'(bus.rx_ready), 32'd1);
    check("adr_after_load", 32'(bus.mem_adr), 32'(n % 256));
    check("wdata_after_load", 32'(bus.mem_writedata), 32'(img[n-1]));
    send_byte(c);
    check("wr_count", 32'(wq_adr.size()), 32'(n));
    errs = 0;
    for (int i = 0; i < n && i < wq_adr.size(); i++)
      if (wq_adr[i] !== 8'(i) || wq_dat[i] !== img[i]) errs++;
    check("wr_order", 32'(errs), 32'd0);
    if (ok) begin
      check("run_done", 32'(boot_done), 32'd1);
      check("run_cpu_reset", 32'(cpu_reset), 32'd0);
      check("run_err", 32'(boot_err), 32'd0);
      check("run_ready", 32'(bus.rx_ready), 32'd0);
    end else begin
      check("err_flag", 32'(boot_err), 32'd1);
      check("err_cpu_reset", 32'(cpu_reset), 32'd1);
      check("err_done", 32'(boot_done), 32'd0);
      check("err_ready", 32'(bus.rx_ready), 32'd0);
      @(negedge clk);
      check("len_after_err_ready", 32'(bus.rx_ready), 32'd1);
      check("len_after_err_flag", 32'(boot_err), 32'd1);
    end
  endtask

  initial begin
    int n;
    logic [7:0] c;

    // Reset values.
    do_reset();
    check("rst_ready", 32'(bus.rx_ready), 32'd1);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done", 32'(boot_done), 32'd0);
    check("rst_err", 32'(boot_err), 32'd0);
    check("rst_memwrite", 32'(bus.mem_memwrite), 32'd0);

    // Basic 3-byte image.
    img = '{8'h20, 8'h07, 8'h10};
    send_image(8'd3, 8'hC9);

    // RUN: cpu bus passes through, rx stream ignored.
    bus.cpu_memwrite  = 1'b1;
    bus.cpu_adr       = 8'd76;
    bus.cpu_writedata = 8'd7;
    bus.rx_valid      = 1'b1;
    bus.rx_data       = 8'h5A;
    #1;
    check("pass_memwrite", 32'(bus.mem_memwrite), 32'd1);
    check("pass_adr", 32'(bus.mem_adr), 32'd76);
    check("pass_wdata", 32'(bus.mem_writedata), 32'd7);
    check("pass_ready", 32'(bus.rx_ready), 32'd0);
    @(negedge clk);
    check("run_hold_done", 32'(boot_done), 32'd1);
    check("run_hold_ready", 32'(bus.rx_ready), 32'd0);
    bus.cpu_memwrite = 1'b0;
    bus.rx_valid     = 1'b0;
    #1;
    check("pass_memwrite_low", 32'(bus.mem_memwrite), 32'd0);

    // Bad checksum, then a good image clears the error.
    do_reset();
    img = '{8'h20, 8'h07, 8'h10};
    send_image(8'd3, 8'h00);
    send_image(8'd3, 8'hC9);

    // Zero length means 256 bytes; address wraps back to 0.
    do_reset();
    img.delete();
    for (int i = 0; i < 256; i++) img.push_back(8'h01);
    send_image(8'd0, 8'h00);

    // Randomized images with stalls; half with random checksums.
    for (int k = 0; k < 6; k++) begin
      do_reset();
      rand_gap = 1'b1;
      n = $urandom_range(1, 40);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(8'($urandom));
      c = 8'($urandom);
      if (k % 2 == 0) begin
        c = 8'h00;
        foreach (img[i]) c = c - img[i];
      end
      send_image(8'(n), c);
    end
    rand_gap = 1'b0;

    // Reset mid-load: prior writes stay, next byte is a fresh length.
    do_reset();
    send_byte(8'd3);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_ready", 32'(bus.rx_ready), 32'd1);
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_err", 32'(boot_err), 32'd0);
    check("midrst_mem0", 32'(tb_mem[0]), 32'h11);
    check("midrst_mem1", 32'(tb_mem[1]), 32'h22);
    img = '{8'hAB};
    send_image(8'd1, 8'h55);
    check("midrst_mem1_kept", 32'(tb_mem[1]), 32'h22);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
